polar_to_cartesian_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational six-angle polar converter.
- Accepts packed {theta_index, r} samples from the sonar/IR sweep logic on a valid/ready handshake and returns signed cartesian x/y for the display and target-tracking blocks.
- Angle grid is configurable: degrees = ANGLE_BASE + ANGLE_STEP*(index - IDX_FIRST), anywhere in 0..180.
- Uses an internal quarter-wave sine ROM and a 3-stage pipeline with full backpressure.

---
 rtl/polar_to_cartesian_pipe.sv | 169 ++++++++++++++++
 tb/tb_polar_to_cartesian_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_to_cartesian_pipe.sv
// Pipelined polar-to-cartesian converter: {index, r} in, signed x/y out on a
// valid/ready handshake. Fold, ROM read, multiply/round, sign/output stages.
module polar_to_cartesian_pipe #(
  parameter int R_WIDTH     = 8,
  parameter int THETA_WIDTH = 4,
  parameter int OUT_WIDTH   = 12,
  parameter int SIN_FRAC    = 8,
  parameter int ANGLE_BASE  = 15,
  parameter int ANGLE_STEP  = 30,
  parameter int IDX_FIRST   = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [R_WIDTH+THETA_WIDTH-1:0] r_theta,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           x_value,
  output logic [OUT_WIDTH-1:0]           y_value,
  output logic                           angle_err
);

  localparam int MW   = R_WIDTH + SIN_FRAC + 1;
  localparam int TW   = SIN_FRAC + 1;
  localparam int HALF = 1 << (SIN_FRAC - 1);

  // Quarter-wave table round(sin(a deg) * 256); entries are at 8 fractional bits.
  function automatic logic [TW-1:0] sin_rom(input logic [6:0] a);
    logic [8:0] v;
    case (a)
      7'd0:  v = 9'd0;   7'd1:  v = 9'd4;   7'd2:  v = 9'd9;   7'd3:  v = 9'd13;  7'd4:  v = 9'd18;
      7'd5:  v = 9'd22;  7'd6:  v = 9'd27;  7'd7:  v = 9'd31;  7'd8:  v = 9'd36;  7'd9:  v = 9'd40;
      7'd10: v = 9'd44;  7'd11: v = 9'd49;  7'd12: v = 9'd53;  7'd13: v = 9'd58;  7'd14: v = 9'd62;
      7'd15: v = 9'd66;  7'd16: v = 9'd71;  7'd17: v = 9'd75;  7'd18: v = 9'd79;  7'd19: v = 9'd83;
      7'd20: v = 9'd88;  7'd21: v = 9'd92;  7'd22: v = 9'd96;  7'd23: v = 9'd100; 7'd24: v = 9'd104;
      7'd25: v = 9'd108; 7'd26: v = 9'd112; 7'd27: v = 9'd116; 7'd28: v = 9'd120; 7'd29: v = 9'd124;
      7'd30: v = 9'd128; 7'd31: v = 9'd132; 7'd32: v = 9'd136; 7'd33: v = 9'd139; 7'd34: v = 9'd143;
      7'd35: v = 9'd147; 7'd36: v = 9'd150; 7'd37: v = 9'd154; 7'd38: v = 9'd158; 7'd39: v = 9'd161;
      7'd40: v = 9'd165; 7'd41: v = 9'd168; 7'd42: v = 9'd171; 7'd43: v = 9'd175; 7'd44: v = 9'd178;
      7'd45: v = 9'd181; 7'd46: v = 9'd184; 7'd47: v = 9'd187; 7'd48: v = 9'd190; 7'd49: v = 9'd193;
      7'd50: v = 9'd196; 7'd51: v = 9'd199; 7'd52: v = 9'd202; 7'd53: v = 9'd204; 7'd54: v = 9'd207;
      7'd55: v = 9'd210; 7'd56: v = 9'd212; 7'd57: v = 9'd215; 7'd58: v = 9'd217; 7'd59: v = 9'd219;
      7'd60: v = 9'd222; 7'd61: v = 9'd224; 7'd62: v = 9'd226; 7'd63: v = 9'd228; 7'd64: v = 9'd230;
      7'd65: v = 9'd232; 7'd66: v = 9'd234; 7'd67: v = 9'd236; 7'd68: v = 9'd237; 7'd69: v = 9'd239;
      7'd70: v = 9'd241; 7'd71: v = 9'd242; 7'd72: v = 9'd243; 7'd73: v = 9'd245; 7'd74: v = 9'd246;
      7'd75: v = 9'd247; 7'd76: v = 9'd248; 7'd77: v = 9'd249; 7'd78: v = 9'd250; 7'd79: v = 9'd251;
      7'd80: v = 9'd252; 7'd81: v = 9'd253; 7'd82: v = 9'd254; 7'd83: v = 9'd254; 7'd84: v = 9'd255;
      7'd85: v = 9'd255; 7'd86: v = 9'd255; 7'd87: v = 9'd256; 7'd88: v = 9'd256; 7'd89: v = 9'd256;
      7'd90: v = 9'd256;
      default: v = 9'd0;
    endcase
    return TW'(v);
  endfunction

  // Rounded r*T >> SIN_FRAC; never exceeds r.
  function automatic logic [R_WIDTH:0] mag_calc(input logic [R_WIDTH-1:0] r, input logic [TW-1:0] t);
    logic [MW-1:0] p;
    p = MW'(r) * MW'(t) + MW'(HALF);
    return (R_WIDTH+1)'(p >> SIN_FRAC);
  endfunction

  logic                   en_s;
  logic [R_WIDTH-1:0]     r_in_s;
  logic [THETA_WIDTH-1:0] idx_s;
  logic signed [31:0]     deg_s;
  logic                   err_s, xneg_s;
  logic [6:0]             cos_a_s, sin_a_s;

  logic                   s1_valid_r, s1_xneg_r, s1_err_r;
  logic [R_WIDTH-1:0]     s1_r_r;
  logic [6:0]             s1_cos_a_r, s1_sin_a_r;
  logic                   s2_valid_r, s2_xneg_r, s2_err_r;
  logic [R_WIDTH-1:0]     s2_r_r;
  logic [TW-1:0]          s2_cos_t_r, s2_sin_t_r;
  logic                   s3_valid_r, s3_xneg_r, s3_err_r;
  logic [R_WIDTH:0]       s3_xmag_r, s3_ymag_r;
  logic                   out_valid_r, angle_err_r;
  logic [OUT_WIDTH-1:0]   x_r, y_r, x_ext_s, x_next_s, y_next_s;

  assign en_s      = ~out_valid_r | out_ready;
  assign in_ready  = en_s;
  assign out_valid = out_valid_r;
  assign x_value   = x_r;
  assign y_value   = y_r;
  assign angle_err = angle_err_r;
  assign r_in_s    = r_theta[R_WIDTH-1:0];
  assign idx_s     = r_theta[R_WIDTH+THETA_WIDTH-1:R_WIDTH];

  // Angle from index, range check, and fold onto the 0..90 quarter wave.
  always_comb begin
    deg_s   = 32'(ANGLE_BASE) + 32'(ANGLE_STEP) * (32'(idx_s) - 32'(IDX_FIRST));
    err_s   = (32'(idx_s) < 32'(IDX_FIRST)) || (deg_s > 32'sd180) || (deg_s < 32'sd0);
    cos_a_s = 7'd0;
    sin_a_s = 7'd0;
    xneg_s  = 1'b0;
    if (err_s) begin
      cos_a_s = 7'd0;
      sin_a_s = 7'd0;
    end else if (deg_s <= 32'sd90) begin
      cos_a_s = 7'(32'sd90 - deg_s);
      sin_a_s = 7'(deg_s);
    end else begin
      cos_a_s = 7'(deg_s - 32'sd90);
      sin_a_s = 7'(32'sd180 - deg_s);
      xneg_s  = 1'b1;
    end
  end

  // Stage 1: fold results.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0; s1_xneg_r <= 1'b0; s1_err_r <= 1'b0;
      s1_r_r <= {R_WIDTH{1'b0}}; s1_cos_a_r <= 7'd0; s1_sin_a_r <= 7'd0;
    end else if (en_s) begin
      s1_valid_r <= in_valid; s1_xneg_r <= xneg_s; s1_err_r <= err_s;
      s1_r_r <= r_in_s; s1_cos_a_r <= cos_a_s; s1_sin_a_r <= sin_a_s;
    end
  end

  // Stage 2: registered ROM reads for the cos and sin paths.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_r <= 1'b0; s2_xneg_r <= 1'b0; s2_err_r <= 1'b0;
      s2_r_r <= {R_WIDTH{1'b0}}; s2_cos_t_r <= {TW{1'b0}}; s2_sin_t_r <= {TW{1'b0}};
    end else if (en_s) begin
      s2_valid_r <= s1_valid_r; s2_xneg_r <= s1_xneg_r; s2_err_r <= s1_err_r;
      s2_r_r <= s1_r_r; s2_cos_t_r <= sin_rom(s1_cos_a_r); s2_sin_t_r <= sin_rom(s1_sin_a_r);
    end
  end

  // Stage 3: multiply and round both magnitudes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s3_valid_r <= 1'b0; s3_xneg_r <= 1'b0; s3_err_r <= 1'b0;
      s3_xmag_r <= {(R_WIDTH+1){1'b0}}; s3_ymag_r <= {(R_WIDTH+1){1'b0}};
    end else if (en_s) begin
      s3_valid_r <= s2_valid_r; s3_xneg_r <= s2_xneg_r; s3_err_r <= s2_err_r;
      s3_xmag_r <= mag_calc(s2_r_r, s2_cos_t_r); s3_ymag_r <= mag_calc(s2_r_r, s2_sin_t_r);
    end
  end

  // Sign the x magnitude after rounding so results mirror exactly about 90 deg.
  always_comb begin
    x_ext_s  = OUT_WIDTH'(s3_xmag_r);
    x_next_s = x_ext_s;
    y_next_s = OUT_WIDTH'(s3_ymag_r);
    if (s3_err_r || !s3_valid_r) begin
      x_next_s = {OUT_WIDTH{1'b0}};
      y_next_s = {OUT_WIDTH{1'b0}};
    end else if (s3_xneg_r) begin
      x_next_s = {OUT_WIDTH{1'b0}} - x_ext_s;
    end else begin
      x_next_s = x_ext_s;
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0; angle_err_r <= 1'b0;
      x_r <= {OUT_WIDTH{1'b0}}; y_r <= {OUT_WIDTH{1'b0}};
    end else if (en_s) begin
      out_valid_r <= s3_valid_r; angle_err_r <= s3_valid_r & s3_err_r;
      x_r <= x_next_s; y_r <= y_next_s;
    end
  end

endmodule

// File: tb/tb_polar_to_cartesian_pipe.sv
// Bench for polar_to_cartesian_pipe: directed cases plus random traffic against
// a trigonometric reference model and an in-order scoreboard.
module tb_polar_to_cartesian_pipe;
  localparam real PI = 3.14159265358979;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  logic in_valid_a, in_ready_a, out_valid_a, out_ready_a, angle_err_a;
  logic [11:0] r_theta_a, x_value_a, y_value_a;
  logic in_valid_b, in_ready_b, out_valid_b, out_ready_b, angle_err_b;
  logic [11:0] r_theta_b, x_value_b, y_value_b;

  polar_to_cartesian_pipe dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .r_theta(r_theta_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .x_value(x_value_a), .y_value(y_value_a), .angle_err(angle_err_a));

  polar_to_cartesian_pipe #(.ANGLE_BASE(0), .ANGLE_STEP(90), .IDX_FIRST(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .r_theta(r_theta_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .x_value(x_value_b), .y_value(y_value_b), .angle_err(angle_err_b));

  typedef struct { int x; int y; int e; } res_t;
  res_t q_a[$];
  res_t q_b[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tab(input real v);
    return $rtoi($floor(((v < 0.0) ? -v : v) * 256.0 + 0.5));
  endfunction

  function automatic res_t ref_model(input int r, input int idx, input int base, input int step, input int first);
    res_t res;
    int deg;
    real rad;
    deg = base + step * (idx - first);
    rad = deg * PI / 180.0;
    if (idx < first || deg > 180 || deg < 0) begin
      res.x = 0; res.y = 0; res.e = 1;
    end else begin
      res.e = 0;
      res.y = (r * tab($sin(rad)) + 128) / 256;
      res.x = (r * tab($cos(rad)) + 128) / 256;
      if (deg > 90) res.x = -res.x;
    end
    return res;
  endfunction

  always @(negedge clock) begin : mon_a
    res_t exp_v;
    if (!reset_n) q_a.delete();
    else begin
      if (out_valid_a) begin
        check_val("a_pending", int'(q_a.size() > 0), 1);
        if (q_a.size() > 0) begin
          exp_v = q_a[0];
          check_val("a_x", $signed(x_value_a), exp_v.x);
          check_val("a_y", $signed(y_value_a), exp_v.y);
          check_val("a_err", int'(angle_err_a), exp_v.e);
          if (out_ready_a) void'(q_a.pop_front());
        end
      end
      if (in_valid_a && in_ready_a)
        q_a.push_back(ref_model(int'(r_theta_a[7:0]), int'(r_theta_a[11:8]), 15, 30, 1));
    end
  end

  always @(negedge clock) begin : mon_b
    res_t exp_v;
    if (!reset_n) q_b.delete();
    else begin
      if (out_valid_b) begin
        check_val("b_pending", int'(q_b.size() > 0), 1);
        if (q_b.size() > 0) begin
          exp_v = q_b[0];
          check_val("b_x", $signed(x_value_b), exp_v.x);
          check_val("b_y", $signed(y_value_b), exp_v.y);
          check_val("b_err", int'(angle_err_b), exp_v.e);
          if (out_ready_b) void'(q_b.pop_front());
        end
      end
      if (in_valid_b && in_ready_b)
        q_b.push_back(ref_model(int'(r_theta_b[7:0]), int'(r_theta_b[11:8]), 0, 90, 0));
    end
  end

  task automatic sync();
    @(posedge clock); #1;
  endtask

  task automatic send(input bit sel, input int r, input int idx);
    int n = 0;
    if (sel) begin in_valid_b = 1'b1; r_theta_b = {4'(idx), 8'(r)}; end
    else begin in_valid_a = 1'b1; r_theta_a = {4'(idx), 8'(r)}; end
    @(negedge clock);
    while (!(sel ? in_ready_b : in_ready_a)) begin
      n++;
      if (n > 50) begin check_val("send_timeout", n, 0); break; end
      @(negedge clock);
    end
    sync();
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic wait_out(input bit sel, output int lat);
    lat = 0;
    @(negedge clock);
    while (!(sel ? out_valid_b : out_valid_a)) begin
      lat++;
      if (lat > 20) begin check_val("out_timeout", lat, 0); return; end
      @(negedge clock);
    end
  endtask

  task automatic check_out(input bit sel, input string tag, input int xe, input int ye, input int ee);
    check_val({tag, "_x"}, sel ? $signed(x_value_b) : $signed(x_value_a), xe);
    check_val({tag, "_y"}, sel ? $signed(y_value_b) : $signed(y_value_a), ye);
    check_val({tag, "_err"}, int'(sel ? angle_err_b : angle_err_a), ee);
  endtask

  task automatic drain();
    int n = 0;
    out_ready_a = 1'b1; out_ready_b = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0;
    @(negedge clock);
    while ((q_a.size() != 0 || q_b.size() != 0 || out_valid_a || out_valid_b) && n < 40) begin
      n++;
      @(negedge clock);
    end
    check_val("drain_a_empty", q_a.size(), 0);
    check_val("drain_b_empty", q_b.size(), 0);
    sync();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    int n;
    reset_n = 1'b0;
    in_valid_a = 1'b0; r_theta_a = 12'd0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; r_theta_b = 12'd0; out_ready_b = 1'b1;
    #1;
    check_val("rst_out_valid", int'(out_valid_a), 0);
    check_val("rst_in_ready", int'(in_ready_a), 1);
    check_out(1'b0, "rst", 0, 0, 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    sync();

    // Single samples: latency and known values.
    send(1'b0, 200, 1);
    wait_out(1'b0, lat);
    check_val("latency", lat, 3);
    check_out(1'b0, "d15", 193, 52, 0);
    sync();
    send(1'b0, 100, 2); wait_out(1'b0, lat); check_out(1'b0, "d45", 71, 71, 0); sync();
    send(1'b0, 255, 6); wait_out(1'b0, lat); check_out(1'b0, "d165", -246, 66, 0); sync();
    send(1'b0, 0, 4);   wait_out(1'b0, lat); check_out(1'b0, "r0", 0, 0, 0); sync();

    // Back-to-back with a five-cycle consumer stall mid-stream.
    fork
      begin
        for (int i = 1; i <= 6; i++) send(1'b0, 255, i);
      end
      begin
        repeat (2) @(posedge clock);
        #1 out_ready_a = 1'b0;
        n = 0;
        @(negedge clock);
        while (!out_valid_a && n < 20) begin n++; @(negedge clock); end
        for (int k = 0; k < 5; k++) begin
          check_val("stall_in_ready", int'(in_ready_a), 0);
          check_val("stall_out_valid", int'(out_valid_a), 1);
          if (k < 4) @(negedge clock);
        end
        sync();
        out_ready_a = 1'b1;
      end
    join
    drain();

    // Out-of-range indices followed by a legal sample.
    send(1'b0, 50, 0);
    send(1'b0, 99, 7);
    send(1'b0, 200, 3);
    wait_out(1'b0, lat);
    check_out(1'b0, "idx0", 0, 0, 1);
    @(negedge clock); check_out(1'b0, "idx7", 0, 0, 1);
    @(negedge clock); check_out(1'b0, "d75", 52, 193, 0);
    sync();
    drain();

    // Cardinal grid on the second instance.
    send(1'b1, 255, 0);
    send(1'b1, 255, 1);
    send(1'b1, 255, 2);
    wait_out(1'b1, lat);
    check_out(1'b1, "b0", 255, 0, 0);
    @(negedge clock); check_out(1'b1, "b90", 0, 255, 0);
    @(negedge clock); check_out(1'b1, "b180", -255, 0, 0);
    sync();
    drain();

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid_a  = ($urandom_range(0, 3) != 0);
      r_theta_a   = 12'($urandom);
      out_ready_a = ($urandom_range(0, 3) != 0);
      in_valid_b  = ($urandom_range(0, 1) != 0);
      r_theta_b   = {4'($urandom_range(0, 2)), 8'($urandom)};
      out_ready_b = ($urandom_range(0, 2) != 0);
      sync();
    end
    drain();

    // Asynchronous reset with samples in flight.
    send(1'b0, 200, 1);
    send(1'b0, 50, 2);
    send(1'b0, 60, 3);
    send(1'b0, 70, 4);
    check_val("pre_rst_out_valid", int'(out_valid_a), 1);
    check_val("pre_rst_x", $signed(x_value_a), 193);
    #2 reset_n = 1'b0;
    #1;
    check_val("async_rst_out_valid", int'(out_valid_a), 0);
    check_out(1'b0, "async_rst", 0, 0, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check_val("post_rst_no_stale", int'(out_valid_a), 0);
    end
    sync();
    send(1'b0, 200, 3);
    wait_out(1'b0, lat);
    check_out(1'b0, "post_rst_d75", 52, 193, 0);
    sync();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
